wb_rr_arbiter: RTL and testbench

//  Two-master, one-slave Wishbone arbiter with round-robin grant. It shares one slave port
//  (memory/IO fabric) between the multi-cycle CPU (m0) and a second master (m1), e.g. a

---
 rtl/wb_rr_arbiter_pkg.sv | 22 ++
 rtl/wb_arb_timer.sv | 37 +++
 rtl/wb_rr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and defaults for the two-master round-robin Wishbone arbiter.
package wb_rr_arbiter_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;
    localparam int WB_SW = WB_DW / 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ACC  = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_e;

    // Master index to grant: a sole requester wins, a tie goes to whoever was not served last.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_gnt);
        if (req == 2'b11) begin
            return ~last_gnt;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// Access watchdog: counts cycles while enabled, flags the last allowed cycle.
module wb_arb_timer #(
    parameter int TMO_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry is seen during the TMO_CYC-th enabled cycle so the abort lands exactly TMO_CYC cycles in.
    assign expired_o = en_i && (cnt_q == CW'(TMO_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master / one-slave Wishbone arbiter with round-robin grant and stretched acks.
// Optional access timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int DW      = WB_DW,
    parameter int AW      = WB_AW,
    parameter int SW      = WB_SW,
    parameter int TMO_CYC = 255
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [SW-1:0] m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_stb_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [SW-1:0] m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_stb_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [DW-1:0] s_dat_o,
    output logic [AW-1:0] s_adr_o,
    output logic [SW-1:0] s_sel_o,
    output logic          s_we_o,
    output logic          s_stb_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    logic [1:0]    m_stb;
    logic [1:0]    m_we;
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_wdat [2];
    logic [SW-1:0] m_sel [2];

    assign m_stb     = {m1_stb_i, m0_stb_i};
    assign m_we      = {m1_we_i, m0_we_i};
    assign m_adr[0]  = m0_adr_i;
    assign m_adr[1]  = m1_adr_i;
    assign m_wdat[0] = m0_dat_i;
    assign m_wdat[1] = m1_dat_i;
    assign m_sel[0]  = m0_sel_i;
    assign m_sel[1]  = m1_sel_i;

    arb_state_e    state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [DW-1:0] s_dat_q, s_dat_d;
    logic [AW-1:0] s_adr_q, s_adr_d;
    logic [SW-1:0] s_sel_q, s_sel_d;
    logic          s_we_q, s_we_d;
    logic          s_stb_q, s_stb_d;
    logic [DW-1:0] m_dat_q [2];
    logic [DW-1:0] m_dat_d [2];
    logic [1:0]    m_ack_q, m_ack_d;
    logic [1:0]    m_err_q, m_err_d;
    logic          pick;
    logic          tmo_expired;

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_timer #(
        .TMO_CYC (TMO_CYC)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (state_q != ARB_ACC),
        .en_i      (state_q == ARB_ACC),
        .expired_o (tmo_expired)
    );
`else
    logic unused_tmo;
    assign unused_tmo  = (TMO_CYC != 0);
    assign tmo_expired = 1'b0;
`endif

    // While an access is in flight last_gnt_q names the master that owns the slave.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        s_dat_d    = s_dat_q;
        s_adr_d    = s_adr_q;
        s_sel_d    = s_sel_q;
        s_we_d     = s_we_q;
        s_stb_d    = s_stb_q;
        m_dat_d    = m_dat_q;
        m_ack_d    = m_ack_q;
        m_err_d    = m_err_q;
        pick       = rr_pick(m_stb, last_gnt_q);

        case (state_q)
            ARB_IDLE: begin
                if (m_stb != 2'b00) begin
                    s_adr_d    = m_adr[pick];
                    s_dat_d    = m_wdat[pick];
                    s_sel_d    = m_sel[pick];
                    s_we_d     = m_we[pick];
                    s_stb_d    = 1'b1;
                    last_gnt_d = pick;
                    gnt_d      = pick ? 2'b10 : 2'b01;
                    state_d    = ARB_ACC;
                end
            end
            ARB_ACC: begin
                // A master that gives up wins over a coincident or late slave ack.
                if (!m_stb[last_gnt_q]) begin
                    s_stb_d = 1'b0;
                    gnt_d   = 2'b00;
                    state_d = ARB_IDLE;
                end else if (s_ack_i) begin
                    m_dat_d[last_gnt_q] = s_dat_i;
                    m_ack_d[last_gnt_q] = 1'b1;
                    s_stb_d             = 1'b0;
                    state_d             = ARB_HOLD;
                end else if (tmo_expired) begin
                    m_dat_d[last_gnt_q] = '0;
                    m_err_d[last_gnt_q] = 1'b1;
                    s_stb_d             = 1'b0;
                    state_d             = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (!m_stb[last_gnt_q]) begin
                    m_ack_d = 2'b00;
                    m_err_d = 2'b00;
                    gnt_d   = 2'b00;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= '0;
            s_dat_q    <= '0;
            s_adr_q    <= '0;
            s_sel_q    <= '0;
            s_we_q     <= 1'b0;
            s_stb_q    <= 1'b0;
            m_dat_q    <= '{default: '0};
            m_ack_q    <= '0;
            m_err_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            s_dat_q    <= s_dat_d;
            s_adr_q    <= s_adr_d;
            s_sel_q    <= s_sel_d;
            s_we_q     <= s_we_d;
            s_stb_q    <= s_stb_d;
            m_dat_q    <= m_dat_d;
            m_ack_q    <= m_ack_d;
            m_err_q    <= m_err_d;
        end
    end

    assign m0_dat_o = m_dat_q[0];
    assign m1_dat_o = m_dat_q[1];
    assign m0_ack_o = m_ack_q[0];
    assign m1_ack_o = m_ack_q[1];
    assign m0_err_o = m_err_q[0];
    assign m1_err_o = m_err_q[1];
    assign s_dat_o  = s_dat_q;
    assign s_adr_o  = s_adr_q;
    assign s_sel_o  = s_sel_q;
    assign s_we_o   = s_we_q;
    assign s_stb_o  = s_stb_q;
    assign gnt_o    = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (timeout scenario follows WB_ARB_TIMEOUT_EN).
module tb_wb_rr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] m0_dat_i, m0_adr_i, m0_dat_o;
    logic [31:0] m1_dat_i, m1_adr_i, m1_dat_o;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_we_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic        m1_we_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [31:0] s_dat_o, s_adr_o, s_dat_i;
    logic        s_we_o, s_stb_o, s_ack_i;
    logic [1:0]  gnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    wb_rr_arbiter #(
        .DW(32), .AW(32), .SW(4), .TMO_CYC(8)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ack_pulse(input logic [31:0] d);
        s_dat_i = d;
        s_ack_i = 1'b1;
        tick();
        s_ack_i = 1'b0;
        s_dat_i = 32'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        #12;
        n_checks++; if ({s_stb_o, s_we_o, gnt_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 8'h0) begin n_fail++; $display("FAIL reset_ctrl: got %b, expected 0", {s_stb_o, s_we_o, gnt_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
        n_checks++; if ({s_adr_o, s_dat_o, s_sel_o} !== 68'h0) begin n_fail++; $display("FAIL reset_slave_bus: got %h, expected 0", {s_adr_o, s_dat_o, s_sel_o}); end
        n_checks++; if ({m0_dat_o, m1_dat_o} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h, expected 0", {m0_dat_o, m1_dat_o}); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        tick();
        n_checks++; if ({gnt_o, s_stb_o} !== 3'b000) begin n_fail++; $display("FAIL reset_idle: got %b, expected 000", {gnt_o, s_stb_o}); end
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        int stb_cnt = 0;
        int hold_bad = 0;
        m0_adr_i = 32'h0000_0010; m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (s_stb_o === 1'b1) stb_cnt++;
            if (i == 0) begin
                n_checks++; if ({gnt_o, s_adr_o, s_we_o} !== {2'b01, 32'h10, 1'b0}) begin n_fail++; $display("FAIL t1_grant: got gnt=%b adr=%h we=%b, expected gnt=01 adr=10 we=0", gnt_o, s_adr_o, s_we_o); end
            end
            s_ack_i = (i == 3);
            s_dat_i = (i == 3) ? 32'h1234_5678 : 32'h0;
        end
        n_checks++; if (stb_cnt !== 4) begin n_fail++; $display("FAIL t1_stb_cycles: got %0d, expected 4", stb_cnt); end
        n_checks++; if ({m0_ack_o, m0_dat_o, m1_ack_o} !== {1'b1, 32'h1234_5678, 1'b0}) begin n_fail++; $display("FAIL t1_ack_data: got ack=%b dat=%h m1_ack=%b, expected 1 12345678 0", m0_ack_o, m0_dat_o, m1_ack_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h1234_5678 || s_stb_o !== 1'b0) hold_bad++;
        end
        n_checks++; if (hold_bad !== 0) begin n_fail++; $display("FAIL t1_hold: got %0d bad cycles, expected 0", hold_bad); end
        m0_stb_i = 1'b0;
        tick();
        n_checks++; if ({m0_ack_o, gnt_o, s_stb_o} !== 4'b0000) begin n_fail++; $display("FAIL t1_release: got %b, expected 0000", {m0_ack_o, gnt_o, s_stb_o}); end
        $display("test_single_read done");
    endtask

    task automatic test_tie();
        apply_reset();
        m0_adr_i = 32'hA0; m0_we_i = 1'b0; m1_adr_i = 32'hB0; m1_we_i = 1'b0;
        m0_stb_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        n_checks++; if ({gnt_o, s_adr_o} !== {2'b01, 32'hA0}) begin n_fail++; $display("FAIL t2_first_m0: got gnt=%b adr=%h, expected 01 a0", gnt_o, s_adr_o); end
        ack_pulse(32'h1111_0000);
        n_checks++; if ({m0_ack_o, m0_dat_o, m1_ack_o} !== {1'b1, 32'h1111_0000, 1'b0}) begin n_fail++; $display("FAIL t2_m0_ack: got %b %h %b, expected 1 11110000 0", m0_ack_o, m0_dat_o, m1_ack_o); end
        m0_stb_i = 1'b0;
        tick();
        n_checks++; if ({gnt_o, m0_ack_o} !== 3'b000) begin n_fail++; $display("FAIL t2_gap: got %b, expected 000", {gnt_o, m0_ack_o}); end
        tick();
        n_checks++; if ({gnt_o, s_adr_o} !== {2'b10, 32'hB0}) begin n_fail++; $display("FAIL t2_then_m1: got gnt=%b adr=%h, expected 10 b0", gnt_o, s_adr_o); end
        ack_pulse(32'h2222_0000);
        n_checks++; if ({m1_ack_o, m1_dat_o, m0_ack_o} !== {1'b1, 32'h2222_0000, 1'b0}) begin n_fail++; $display("FAIL t2_m1_ack: got %b %h %b, expected 1 22220000 0", m1_ack_o, m1_dat_o, m0_ack_o); end
        m1_stb_i = 1'b0;
        tick();
        m0_stb_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL t2_second_pair_m0: got %b, expected 01", gnt_o); end
        ack_pulse(32'h3333_0000);
        m0_stb_i = 1'b0;
        tick();
        tick();
        n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL t2_second_pair_m1: got %b, expected 10", gnt_o); end
        ack_pulse(32'h4444_0000);
        m1_stb_i = 1'b0;
        tick();
        $display("test_tie done");
    endtask

    task automatic test_write_while_busy();
        int wait_bad = 0;
        int hold_bad = 0;
        m1_adr_i = 32'h0000_0100; m1_dat_i = 32'hCAFE_F00D; m1_sel_i = 4'hF; m1_we_i = 1'b1;
        m1_stb_i = 1'b1;
        tick();
        n_checks++; if ({gnt_o, s_adr_o, s_dat_o, s_sel_o, s_we_o} !== {2'b10, 32'h100, 32'hCAFE_F00D, 4'hF, 1'b1}) begin n_fail++; $display("FAIL t3_m1_write: got gnt=%b adr=%h dat=%h sel=%h we=%b", gnt_o, s_adr_o, s_dat_o, s_sel_o, s_we_o); end
        m0_adr_i = 32'h20; m0_dat_i = 32'h0; m0_sel_i = 4'h3; m0_we_i = 1'b0; m0_stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (gnt_o !== 2'b10 || m0_ack_o !== 1'b0) wait_bad++;
        end
        ack_pulse(32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            if (gnt_o !== 2'b10 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b1) wait_bad++;
            tick();
        end
        n_checks++; if (wait_bad !== 0) begin n_fail++; $display("FAIL t3_m0_waits: got %0d bad cycles, expected 0", wait_bad); end
        m1_stb_i = 1'b0;
        tick();
        n_checks++; if ({gnt_o, m1_ack_o} !== 3'b000) begin n_fail++; $display("FAIL t3_m1_release: got %b, expected 000", {gnt_o, m1_ack_o}); end
        tick();
        n_checks++; if ({gnt_o, s_adr_o, s_sel_o, s_we_o} !== {2'b01, 32'h20, 4'h3, 1'b0}) begin n_fail++; $display("FAIL t3_m0_next: got gnt=%b adr=%h sel=%h we=%b", gnt_o, s_adr_o, s_sel_o, s_we_o); end
        ack_pulse(32'h5A5A_0020);
        for (int i = 0; i < 30; i++) begin
            if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h5A5A_0020) hold_bad++;
            tick();
        end
        n_checks++; if (hold_bad !== 0) begin n_fail++; $display("FAIL t3_m0_hold: got %0d bad cycles, expected 0", hold_bad); end
        m0_stb_i = 1'b0;
        tick();
        n_checks++; if (m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL t3_m0_release: got %b, expected 0", m0_ack_o); end
        $display("test_write_while_busy done");
    endtask

    task automatic test_abort();
        m0_adr_i = 32'h30; m0_we_i = 1'b0; m0_stb_i = 1'b1;
        tick();
        n_checks++; if ({gnt_o, s_stb_o} !== 3'b011) begin n_fail++; $display("FAIL t4_grant: got %b, expected 011", {gnt_o, s_stb_o}); end
        tick();
        m0_stb_i = 1'b0;
        tick();
        n_checks++; if ({s_stb_o, gnt_o, m0_ack_o} !== 4'b0000) begin n_fail++; $display("FAIL t4_abort: got %b, expected 0000", {s_stb_o, gnt_o, m0_ack_o}); end
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'h9999_9999;
        tick();
        s_ack_i = 1'b0; s_dat_i = 32'h0;
        n_checks++; if ({m0_ack_o, m0_err_o, s_stb_o, gnt_o} !== 5'b00000) begin n_fail++; $display("FAIL t4_late_ack: got %b, expected 00000", {m0_ack_o, m0_err_o, s_stb_o, gnt_o}); end
        m1_adr_i = 32'h40; m1_we_i = 1'b0; m1_stb_i = 1'b1;
        tick();
        n_checks++; if ({gnt_o, s_stb_o, s_adr_o} !== {2'b10, 1'b1, 32'h40}) begin n_fail++; $display("FAIL t4_idle_again: got gnt=%b stb=%b adr=%h, expected 10 1 40", gnt_o, s_stb_o, s_adr_o); end
        ack_pulse(32'h0000_0040);
        m1_stb_i = 1'b0;
        tick();
        $display("test_abort done");
    endtask

    task automatic test_timeout();
        m0_adr_i = 32'h50; m0_we_i = 1'b0; m0_stb_i = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
        begin
            int stb_cnt = 0;
            bit got_err = 1'b0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (m0_err_o === 1'b1) begin
                    got_err = 1'b1;
                    break;
                end
                if (s_stb_o === 1'b1) stb_cnt++;
            end
            n_checks++; if (got_err !== 1'b1) begin n_fail++; $display("FAIL t5_err_seen: got %b, expected 1", got_err); end
            n_checks++; if (stb_cnt !== 8) begin n_fail++; $display("FAIL t5_acc_cycles: got %0d, expected 8", stb_cnt); end
            n_checks++; if ({m0_dat_o, m0_ack_o, s_stb_o} !== 34'h0) begin n_fail++; $display("FAIL t5_err_outputs: got dat=%h ack=%b stb=%b, expected 0 0 0", m0_dat_o, m0_ack_o, s_stb_o); end
            m0_stb_i = 1'b0;
            tick();
            n_checks++; if (m0_err_o !== 1'b0) begin n_fail++; $display("FAIL t5_err_release: got %b, expected 0", m0_err_o); end
        end
`else
        begin
            int bad = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (m0_err_o !== 1'b0 || m0_ack_o !== 1'b0) bad++;
            end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL t5_no_err: got %0d bad cycles, expected 0", bad); end
            n_checks++; if ({s_stb_o, gnt_o, m0_dat_o} !== {1'b1, 2'b01, 32'h5A5A_0020}) begin n_fail++; $display("FAIL t5_still_waiting: got stb=%b gnt=%b dat=%h, expected 1 01 5a5a0020", s_stb_o, gnt_o, m0_dat_o); end
            m0_stb_i = 1'b0;
            tick();
            n_checks++; if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL t5_abort: got %b, expected 0", s_stb_o); end
        end
`endif
        tick();
        $display("test_timeout done");
    endtask

    task automatic test_reset_in_hold();
        m0_adr_i = 32'h60; m0_we_i = 1'b0; m0_stb_i = 1'b1;
        tick();
        ack_pulse(32'h7777_0001);
        n_checks++; if ({m0_ack_o, m0_dat_o} !== {1'b1, 32'h7777_0001}) begin n_fail++; $display("FAIL t6_in_hold: got %b %h, expected 1 77770001", m0_ack_o, m0_dat_o); end
        #2;
        rst_n_i = 1'b0;
        #1;
        n_checks++; if ({m0_ack_o, m0_dat_o, gnt_o, s_stb_o, s_adr_o} !== 68'h0) begin n_fail++; $display("FAIL t6_async_clear: got ack=%b dat=%h gnt=%b stb=%b adr=%h, expected all 0", m0_ack_o, m0_dat_o, gnt_o, s_stb_o, s_adr_o); end
        m0_stb_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL t6_idle: got %b, expected 00", gnt_o); end
        m0_adr_i = 32'h70; m1_adr_i = 32'h80; m1_we_i = 1'b0;
        m0_stb_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        n_checks++; if ({gnt_o, s_adr_o} !== {2'b01, 32'h70}) begin n_fail++; $display("FAIL t6_regrant: got gnt=%b adr=%h, expected 01 70", gnt_o, s_adr_o); end
        ack_pulse(32'h0BAD_CAFE);
        n_checks++; if ({m0_ack_o, m0_dat_o} !== {1'b1, 32'h0BAD_CAFE}) begin n_fail++; $display("FAIL t6_regrant_ack: got %b %h, expected 1 0badcafe", m0_ack_o, m0_dat_o); end
        m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        tick();
        $display("test_reset_in_hold done");
    endtask

    initial begin
        m0_dat_i = '0; m0_adr_i = '0; m0_sel_i = '0; m0_we_i = 1'b0; m0_stb_i = 1'b0;
        m1_dat_i = '0; m1_adr_i = '0; m1_sel_i = '0; m1_we_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0;
        test_reset();
        test_single_read();
        test_tie();
        test_write_while_busy();
        test_abort();
        test_timeout();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
